piso_serializer: RTL and testbench

//   Parallel-in serial-out transmitter: accepts a WIDTH-bit word over a valid/ready

---
 rtl/piso_serializer.sv | 101 ++++++++++
 tb/tb_piso_serializer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready intake
// and registered sdata/sframe/slast outputs.
module piso_serializer #(
    parameter int   WIDTH      = 4,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pdata,
    input  logic             pvalid,
    output logic             pready,
    output logic             sdata,
    output logic             sframe,
    output logic             slast
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_n;
    logic             sdata_n;
    logic             sframe_n;
    logic             slast_n;
    logic             accept;

    // A new word may enter as soon as the final bit of the current one is out
    assign pready = (state == IDLE) || (cnt == '0);
    assign accept = pvalid && pready;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        shreg_n  = shreg;
        sdata_n  = sdata;
        sframe_n = sframe;
        slast_n  = slast;
        if (accept) begin
            state_n  = SHIFT;
            cnt_n    = CW'(WIDTH - 1);
            shreg_n  = pdata;
            sdata_n  = MSB_FIRST ? pdata[WIDTH-1] : pdata[0];
            sframe_n = 1'b1;
            slast_n  = 1'b0;
        end else begin
            unique case (state)
                SHIFT: begin
                    if (cnt != '0) begin
                        if (MSB_FIRST) begin
                            shreg_n = shreg << 1;
                            sdata_n = shreg[WIDTH-2];
                        end else begin
                            shreg_n = shreg >> 1;
                            sdata_n = shreg[1];
                        end
                        cnt_n   = cnt - CW'(1);
                        slast_n = (cnt == CW'(1));
                    end else begin
                        state_n  = IDLE;
                        sdata_n  = IDLE_LEVEL;
                        sframe_n = 1'b0;
                        slast_n  = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            sdata  <= IDLE_LEVEL;
            sframe <= 1'b0;
            slast  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            sdata  <= sdata_n;
            sframe <= sframe_n;
            slast  <= slast_n;
        end
    end

    // Contents are irrelevant until a word is loaded
    always_ff @(posedge clk) begin
        shreg <= shreg_n;
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first
// instances share stimulus; ends with a random loopback run.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] pdata;
    logic       pvalid;
    logic       pready, sdata, sframe, slast;
    logic       pready_l, sdata_l, sframe_l, slast_l;

    int checks   = 0;
    int failures = 0;

    logic [3:0] sr;
    logic [3:0] expq[$];
    int         got;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .reset(reset), .pdata(pdata), .pvalid(pvalid),
        .pready(pready), .sdata(sdata), .sframe(sframe), .slast(slast)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
        .clk(clk), .reset(reset), .pdata(pdata), .pvalid(pvalid),
        .pready(pready_l), .sdata(sdata_l), .sframe(sframe_l), .slast(slast_l)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sd: MSB-first sdata, sdl: LSB-first sdata; framing identical on both
    task automatic cyc(input string tag, input logic sd, input logic sdl,
                       input logic sf, input logic sl);
        tick();
        chk({tag, ".sdata"}, {3'b0, sdata}, {3'b0, sd});
        chk({tag, ".sdata_l"}, {3'b0, sdata_l}, {3'b0, sdl});
        chk({tag, ".sframe"}, {2'b0, sframe, sframe_l}, {2'b0, sf, sf});
        chk({tag, ".slast"}, {2'b0, slast, slast_l}, {2'b0, sl, sl});
    endtask

    task automatic tick_mon();
        tick();
        if (sframe) sr = {sr[2:0], sdata};
        if (slast) begin
            got++;
            if (expq.size() == 0) begin
                chk("loop.spurious", sr, 4'hx);
            end else begin
                chk("loop.word", sr, expq.pop_front());
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        pdata  = 4'h0;
        pvalid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst.outs", {1'b0, sdata, sframe, slast}, 4'b0000);
        chk("rst.pready", {2'b0, pready, pready_l}, 4'b0011);

        // single word 1011
        pdata  = 4'b1011;
        pvalid = 1'b1;
        cyc("t1.c1", 1, 1, 1, 0);
        pvalid = 1'b0;
        chk("t1.busy", {3'b0, pready}, 4'b0000);
        cyc("t1.c2", 0, 1, 1, 0);
        cyc("t1.c3", 1, 0, 1, 0);
        cyc("t1.c4", 1, 1, 1, 1);
        cyc("t1.c5", 0, 0, 0, 0);
        chk("t1.pready", {3'b0, pready}, 4'b0001);

        // back-to-back 1011 then 0110; pdata changes mid-word
        pdata  = 4'b1011;
        pvalid = 1'b1;
        cyc("t2.c1", 1, 1, 1, 0);
        pdata = 4'b0110;
        cyc("t2.c2", 0, 1, 1, 0);
        cyc("t2.c3", 1, 0, 1, 0);
        cyc("t2.c4", 1, 1, 1, 1);
        chk("t2.pready4", {3'b0, pready}, 4'b0001);
        cyc("t2.c5", 0, 0, 1, 0);
        pvalid = 1'b0;
        cyc("t2.c6", 1, 1, 1, 0);
        cyc("t2.c7", 1, 1, 1, 0);
        cyc("t2.c8", 0, 0, 1, 1);
        cyc("t2.c9", 0, 0, 0, 0);

        // 0001: LSB-first instance sends 1,0,0,0
        pdata  = 4'b0001;
        pvalid = 1'b1;
        cyc("t3.c1", 0, 1, 1, 0);
        pvalid = 1'b0;
        cyc("t3.c2", 0, 0, 1, 0);
        cyc("t3.c3", 0, 0, 1, 0);
        cyc("t3.c4", 1, 0, 1, 1);
        cyc("t3.c5", 0, 0, 0, 0);

        // 1111 pending while 0000 is sent
        pdata  = 4'b0000;
        pvalid = 1'b1;
        cyc("t4.c1", 0, 0, 1, 0);
        pdata = 4'b1111;
        chk("t4.hold1", {3'b0, pready}, 4'b0000);
        cyc("t4.c2", 0, 0, 1, 0);
        chk("t4.hold2", {3'b0, pready}, 4'b0000);
        cyc("t4.c3", 0, 0, 1, 0);
        chk("t4.hold3", {3'b0, pready}, 4'b0000);
        cyc("t4.c4", 0, 0, 1, 1);
        chk("t4.open", {3'b0, pready}, 4'b0001);
        cyc("t4.c5", 1, 1, 1, 0);
        pvalid = 1'b0;
        cyc("t4.c6", 1, 1, 1, 0);
        cyc("t4.c7", 1, 1, 1, 0);
        cyc("t4.c8", 1, 1, 1, 1);
        cyc("t4.c9", 0, 0, 0, 0);

        // reset aborts 1010 in its second bit
        pdata  = 4'b1010;
        pvalid = 1'b1;
        cyc("t5.c1", 1, 0, 1, 0);
        pvalid = 1'b0;
        cyc("t5.c2", 0, 1, 1, 0);
        reset = 1'b1;
        cyc("t5.rst", 0, 0, 0, 0);
        chk("t5.pready", {2'b0, pready, pready_l}, 4'b0011);
        reset  = 1'b0;
        pdata  = 4'b0101;
        pvalid = 1'b1;
        cyc("t5.n1", 0, 1, 1, 0);
        pvalid = 1'b0;
        cyc("t5.n2", 1, 0, 1, 0);
        cyc("t5.n3", 0, 1, 1, 0);
        cyc("t5.n4", 1, 0, 1, 1);
        cyc("t5.n5", 0, 0, 0, 0);

        // random loopback through a 4-stage shift register
        sr  = '0;
        got = 0;
        for (int w = 0; w < 20; w++) begin
            int  gap;
            int  guard;
            logic acc;
            gap = $urandom_range(0, 2);
            pvalid = 1'b0;
            repeat (gap) tick_mon();
            pdata  = 4'($urandom);
            pvalid = 1'b1;
            guard  = 0;
            do begin
                acc = pready;
                if (acc) expq.push_back(pdata);
                tick_mon();
                guard++;
            end while (!acc && guard < 10);
            if (!acc) chk("loop.accept_timeout", 4'h0, 4'h1);
        end
        pvalid = 1'b0;
        repeat (6) tick_mon();
        chk("loop.count", 4'(got), 4'(20));
        chk("loop.drained", 4'(expq.size()), 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
